// File: rtl/keypad_pkg.sv
// Shared types, column constants and key-map decode for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DEB,
        HELD,
        REL_DEB
    } kp_state_t;

    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    function automatic logic [3:0] kp_decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        unique case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'hF;
            4'hE: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] kp_col_idx(input logic [3:0] col);
        logic [1:0] c;
        unique case (col)
            COL1: c = 2'd1;
            COL2: c = 2'd2;
            COL3: c = 2'd3;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

    // Lowest-numbered active row wins when several rows are low.
    function automatic logic [1:0] kp_row_idx(input logic [3:0] fil);
        logic [1:0] r;
        if (!fil[3]) r = 2'd0;
        else if (!fil[2]) r = 2'd1;
        else if (!fil[1]) r = 2'd2;
        else r = 2'd3;
        return r;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the 4 active-low row lines; idles at 4'b1111.
module keypad_sync2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    output logic [3:0] dout
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 4'b1111;
            dout <= 4'b1111;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and one pulse per key.
// Define KEYPAD_SYNC_EN to pass the row lines through a 2-flop synchronizer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 16,
    parameter int DEB_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fil,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEB_CYCLES - 1);

    logic [3:0] samp;

`ifdef KEYPAD_SYNC_EN
    keypad_sync2 u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (fil),
        .dout (samp)
    );
`else
    assign samp = fil;
`endif

    kp_state_t      state, state_d;
    logic [DW-1:0]  dwell, dwell_d;
    logic [DBW-1:0] deb, deb_d;
    logic [3:0]     pat, pat_d;
    logic [1:0]     row, row_d;
    logic [3:0]     col_d, code_d;
    logic           valid_d, held_d;
    logic [3:0]     col_next;

    assign col_next = {col[2:0], col[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            dwell     <= '0;
            deb       <= '0;
            pat       <= 4'b1111;
            row       <= 2'd0;
            col       <= COL0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_d;
            dwell     <= dwell_d;
            deb       <= deb_d;
            pat       <= pat_d;
            row       <= row_d;
            col       <= col_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            key_held  <= held_d;
        end
    end

    always_comb begin
        state_d = state;
        dwell_d = dwell;
        deb_d   = deb;
        pat_d   = pat;
        row_d   = row;
        col_d   = col;
        code_d  = key_code;
        valid_d = 1'b0;
        held_d  = key_held;
        unique case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_d = '0;
                    if (samp != 4'b1111) begin
                        pat_d   = samp;
                        row_d   = kp_row_idx(samp);
                        deb_d   = '0;
                        state_d = PRESS_DEB;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    dwell_d = dwell + 1'b1;
                end
            end
            PRESS_DEB: begin
                if (samp != pat) begin
                    dwell_d = '0;
                    state_d = SCAN;
                end else if (deb == DEB_LAST) begin
                    code_d  = kp_decode(row, kp_col_idx(col));
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    deb_d = deb + 1'b1;
                end
            end
            HELD: begin
                if (samp == 4'b1111) begin
                    deb_d   = '0;
                    state_d = REL_DEB;
                end
            end
            REL_DEB: begin
                if (samp != 4'b1111) begin
                    state_d = HELD;
                end else if (deb == DEB_LAST) begin
                    held_d  = 1'b0;
                    col_d   = col_next;
                    dwell_d = '0;
                    state_d = SCAN;
                end else begin
                    deb_d = deb + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner; a small keypad model drives the row lines.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] fil;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scanner #(
        .SCAN_DIV   (16),
        .DEB_CYCLES (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fil       (fil),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: rows pull low only while the key's column is driven.
    logic       pressed = 1'b0;
    logic [3:0] kcol    = 4'b1110;
    logic [3:0] rowpat  = 4'b1111;
    assign fil = (pressed && col == kcol) ? rowpat : 4'b1111;

    int         ntotal = 0;
    int         npass  = 0;
    int         nvalid = 0;
    logic [3:0] codes[$];

    always @(negedge clk) begin
        if (key_valid) begin
            nvalid = nvalid + 1;
            codes.push_back(key_code);
        end
    end

    function automatic logic [3:0] col_of(input int c);
        logic [3:0] v;
        v = 4'b1111;
        v[c] = 1'b0;
        return v;
    endfunction

    function automatic logic [3:0] row_of(input int r);
        logic [3:0] v;
        v = 4'b1111;
        v[3-r] = 1'b0;
        return v;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int r, input int c, input int hold, input int rel);
        kcol    = col_of(c);
        rowpat  = row_of(r);
        pressed = 1'b1;
        cycles(hold);
        pressed = 1'b0;
        cycles(rel);
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        cycles(3);
        ntotal++;
        if (col !== 4'b1110) $display("FAIL reset_col got %b want 1110", col);
        else npass++;
        ntotal++;
        if (key_code !== 4'h0) $display("FAIL reset_code got %h want 0", key_code);
        else npass++;
        ntotal++;
        if (key_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", key_valid);
        else npass++;
        ntotal++;
        if (key_held !== 1'b0) $display("FAIL reset_held got %b want 0", key_held);
        else npass++;
        rst = 1'b0;
        kcol    = col_of(2);
        rowpat  = row_of(1);
        pressed = 1'b1;
        n = 0;
        while (!key_held && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ntotal++;
        if (key_held !== 1'b1) $display("FAIL reset_reach_held got %b want 1 after %0d", key_held, n);
        else npass++;
        cycles(100);
        rst = 1'b1;
        pressed = 1'b0;
        cycles(5);
        rst = 1'b0;
        nvalid = 0;
        ntotal++;
        if (col !== 4'b1110 || key_held !== 1'b0)
            $display("FAIL reset_mid_held got col=%b held=%b want 1110/0", col, key_held);
        else npass++;
        cycles(2000);
        ntotal++;
        if (nvalid !== 0) $display("FAIL reset_no_valid got %0d pulses want 0", nvalid);
        else npass++;
        ntotal++;
        if (key_code !== 4'h0) $display("FAIL reset_code_after got %h want 0", key_code);
        else npass++;
    endtask

    task automatic test_single_press;
        int n;
        nvalid = 0;
        codes.delete();
        n = 0;
        while (col !== 4'b1101 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ntotal++;
        if (col !== 4'b1101) $display("FAIL single_wait_col got %b want 1101", col);
        else npass++;
        kcol    = 4'b1101;
        rowpat  = 4'b1011;
        pressed = 1'b1;
        cycles(3000);
        ntotal++;
        if (nvalid !== 1 || key_code !== 4'h5)
            $display("FAIL single_press got %0d pulses code %h want 1 code 5", nvalid, key_code);
        else npass++;
        ntotal++;
        if (key_held !== 1'b1) $display("FAIL single_held got %b want 1", key_held);
        else npass++;
        pressed = 1'b0;
        n = 0;
        while (key_held && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ntotal++;
        if (key_held !== 1'b0 || n > 1002)
            $display("FAIL single_release got %0d cycles held=%b want <=1002 held=0", n, key_held);
        else npass++;
        cycles(3000 - n);
        ntotal++;
        if (nvalid !== 1) $display("FAIL single_once got %0d pulses want 1", nvalid);
        else npass++;
    endtask

    task automatic test_digit_sequence;
        nvalid = 0;
        codes.delete();
        press_key(1, 0, 3000, 3000);
        press_key(1, 1, 3000, 3000);
        press_key(3, 3, 3000, 3000);
        press_key(2, 0, 3000, 3000);
        ntotal++;
        if (nvalid !== 4) $display("FAIL digits_count got %0d want 4", nvalid);
        else npass++;
        ntotal++;
        if (codes.size() < 1 || codes[0] !== 4'h4) $display("FAIL digits_0 got %h want 4", codes.size() > 0 ? codes[0] : 4'hx);
        else npass++;
        ntotal++;
        if (codes.size() < 2 || codes[1] !== 4'h5) $display("FAIL digits_1 got %h want 5", codes.size() > 1 ? codes[1] : 4'hx);
        else npass++;
        ntotal++;
        if (codes.size() < 3 || codes[2] !== 4'h0) $display("FAIL digits_2 got %h want 0", codes.size() > 2 ? codes[2] : 4'hx);
        else npass++;
        ntotal++;
        if (codes.size() < 4 || codes[3] !== 4'h7) $display("FAIL digits_3 got %h want 7", codes.size() > 3 ? codes[3] : 4'hx);
        else npass++;
        ntotal++;
        if (key_code !== 4'h7) $display("FAIL digits_final got %h want 7", key_code);
        else npass++;
    endtask

    task automatic test_bounce;
        nvalid = 0;
        codes.delete();
        kcol   = 4'b1110;
        rowpat = 4'b0111;
        for (int i = 0; i < 16; i++) begin
            pressed = i[0];
            cycles(50);
        end
        ntotal++;
        if (nvalid !== 0) $display("FAIL bounce_press_early got %0d pulses want 0", nvalid);
        else npass++;
        pressed = 1'b1;
        cycles(3000);
        ntotal++;
        if (nvalid !== 1 || key_code !== 4'h1)
            $display("FAIL bounce_press got %0d pulses code %h want 1 code 1", nvalid, key_code);
        else npass++;
        for (int i = 0; i < 16; i++) begin
            pressed = i[0];
            cycles(50);
        end
        ntotal++;
        if (key_held !== 1'b1) $display("FAIL bounce_release_held got %b want 1", key_held);
        else npass++;
        pressed = 1'b0;
        cycles(3000);
        ntotal++;
        if (nvalid !== 1) $display("FAIL bounce_release_dup got %0d pulses want 1", nvalid);
        else npass++;
        ntotal++;
        if (key_held !== 1'b0) $display("FAIL bounce_release_done got %b want 0", key_held);
        else npass++;
    endtask

    task automatic test_two_rows;
        nvalid = 0;
        kcol    = 4'b1011;
        rowpat  = 4'b0101;
        pressed = 1'b1;
        cycles(3000);
        pressed = 1'b0;
        cycles(3000);
        ntotal++;
        if (nvalid !== 1) $display("FAIL two_rows_count got %0d want 1", nvalid);
        else npass++;
        ntotal++;
        if (key_code !== 4'h3) $display("FAIL two_rows_code got %h want 3", key_code);
        else npass++;
    endtask

    task automatic test_short_press;
        int n;
        logic [3:0] prev;
        nvalid = 0;
        kcol   = 4'b1101;
        rowpat = 4'b1110;
        n = 0;
        while (col !== 4'b1101 && n < 100) begin
            @(negedge clk);
            n++;
        end
        pressed = 1'b1;
        cycles(500);
        pressed = 1'b0;
        cycles(200);
        ntotal++;
        if (nvalid !== 0) $display("FAIL short_no_valid got %0d pulses want 0", nvalid);
        else npass++;
        ntotal++;
        if (key_held !== 1'b0 || key_code !== 4'h3)
            $display("FAIL short_state got held=%b code=%h want 0/3", key_held, key_code);
        else npass++;
        prev = col;
        n = 0;
        while (col === prev && n < 40) begin
            @(negedge clk);
            n++;
        end
        ntotal++;
        if (col === prev) $display("FAIL short_resume got col stuck at %b want rotation", col);
        else npass++;
        for (int k = 0; k < 2; k++) begin
            prev = col;
            n = 0;
            while (col === prev && n < 40) begin
                @(negedge clk);
                n++;
            end
            ntotal++;
            if (n !== 16 || col !== {prev[2:0], prev[3]})
                $display("FAIL short_dwell got %0d cycles col %b want 16 col %b", n, col, {prev[2:0], prev[3]});
            else npass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_digit_sequence();
        test_bounce();
        test_two_rows();
        test_short_press();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
